// File: rtl/unified_mem_arbiter_pkg.sv
// ============================================================================
// Module  : unified_mem_arbiter_pkg
// Brief   : Shared owner encodings and data width for the I/D memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package unified_mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
// ============================================================================
// Module  : unified_mem_arbiter_if
// Brief   : Fetch, load/store and memory-port bundle shared by core and arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 30
);
  import unified_mem_arbiter_pkg::*;

  logic              i_req;
  logic [XLEN-1:0]   i_adr;
  logic [XLEN-1:0]   i_rdata;
  logic              i_rvalid;
  logic              i_stall;

  logic              d_req;
  logic [3:0]        d_we;
  logic [XLEN-1:0]   d_adr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN-1:0]   d_rdata;
  logic              d_rvalid;
  logic              d_stall;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
    output i_rdata, i_rvalid, i_stall, d_rdata, d_rvalid, d_stall,
    output mem_en, mem_we, mem_adr, mem_wdata
  );

  // Core and memory side
  modport master (
    output i_req, i_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
    input  i_rdata, i_rvalid, i_stall, d_rdata, d_rvalid, d_stall,
    input  mem_en, mem_we, mem_adr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/unified_mem_arbiter_mem_grant_ctl.sv
// ============================================================================
// Module  : mem_grant_ctl
// Brief   : D-priority grant with an I-side starvation counter forcing a win.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_grant_ctl #(
  parameter int STARVE_MAX = 3
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_req,
  input  wire logic d_req,
  output logic      gnt_i,
  output logic      gnt_d
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_force_i;

  assign w_force_i = i_req & (r_starve_cnt == C_STARVE_MAX);
  assign gnt_d     = reset & d_req & ~w_force_i;
  assign gnt_i     = reset & i_req & ~gnt_d;

  // Only a denied I request (which implies a D grant) advances the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
    end else if (gnt_i || !i_req) begin
      r_starve_cnt <= 4'd0;
    end else if (gnt_d && (r_starve_cnt != C_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module  : unified_mem_arbiter
// Brief   : Shares one 1-cycle synchronous memory port between fetch and LSU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int STARVE_MAX = 3
) (
  input wire logic              clk,
  input wire logic              reset,
  unified_mem_arbiter_if.slave  bus
);

  logic            w_gnt_i;
  logic            w_gnt_d;
  owner_e          r_resp_owner;
  owner_e          w_resp_next;
  logic            w_i_resp;
  logic            w_d_rd_resp;
  logic            w_d_resp;
  logic [XLEN-1:0] r_i_rdata;
  logic [XLEN-1:0] r_d_rdata;
  logic            w_unused_adr_bits;

  mem_grant_ctl #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk   (clk),
    .reset (reset),
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .gnt_i (w_gnt_i),
    .gnt_d (w_gnt_d)
  );

  assign bus.mem_en    = w_gnt_i | w_gnt_d;
  assign bus.mem_adr   = w_gnt_d ? bus.d_adr[ADDR_W+1:2] : bus.i_adr[ADDR_W+1:2];
  assign bus.mem_we    = w_gnt_d ? bus.d_we : 4'b0000;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.i_stall   = reset & bus.i_req & ~w_gnt_i;
  assign bus.d_stall   = reset & bus.d_req & ~w_gnt_d;

  assign w_unused_adr_bits = ^{bus.i_adr[1:0], bus.d_adr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_resp_owner <= OWN_NONE;
    end else begin
      r_resp_owner <= w_resp_next;
    end
  end

  // Response decode is qualified by reset so an in-flight beat never surfaces
  always_comb begin
    w_resp_next = OWN_NONE;
    w_i_resp    = 1'b0;
    w_d_rd_resp = 1'b0;
    w_d_resp    = 1'b0;
    if (w_gnt_i) begin
      w_resp_next = OWN_I;
    end else if (w_gnt_d) begin
      w_resp_next = (bus.d_we == 4'b0000) ? OWN_D_RD : OWN_D_WR;
    end
    case (r_resp_owner)
      OWN_I:    w_i_resp = reset;
      OWN_D_RD: begin
        w_d_rd_resp = reset;
        w_d_resp    = reset;
      end
      OWN_D_WR: w_d_resp = reset;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_i_resp) begin
        r_i_rdata <= bus.mem_rdata;
      end
      if (w_d_rd_resp) begin
        r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  // Fresh data is forwarded in the response cycle, then held by the register
  assign bus.i_rvalid = w_i_resp;
  assign bus.d_rvalid = w_d_resp;
  assign bus.i_rdata  = w_i_resp    ? bus.mem_rdata : r_i_rdata;
  assign bus.d_rdata  = w_d_rd_resp ? bus.mem_rdata : r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
// Module  : tb_unified_mem_arbiter
// Brief   : Directed and randomized bench for unified_mem_arbiter with a memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  localparam int ADDR_W     = 30;
  localparam int STARVE_MAX = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] seed_word(input int idx);
    return (32'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Write-first synchronous memory, 256 words aliased over the address space
  logic [31:0] mem_arr [256];
  bit          init_done = 1'b0;
  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= seed_word(i);
      init_done <= 1'b1;
    end else if (bus.mem_en) begin
      w = merge(mem_arr[bus.mem_adr[7:0]], bus.mem_wdata, bus.mem_we);
      mem_arr[bus.mem_adr[7:0]] <= w;
      bus.mem_rdata <= w;
    end
  end

  // Transaction-level reference state
  logic [31:0] ref_mem [256];
  int          starve;
  bit          m_pi, m_prd, m_pwr;
  logic [31:0] m_pdata, m_ihold, m_dhold;

  logic        obs_mem_en, obs_istall, obs_dstall, obs_ivalid, obs_dvalid;
  logic [31:0] obs_mem_adr, obs_irdata, obs_drdata;
  logic [3:0]  obs_mem_we;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rst_n, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd);
    bit e_force, e_gi, e_gd;
    @(negedge clk);
    reset = rst_n;
    bus.i_req = ir; bus.i_adr = ia;
    bus.d_req = dr; bus.d_we = dw; bus.d_adr = da; bus.d_wdata = dd;
    #1;
    obs_mem_en  = bus.mem_en;   obs_mem_we = bus.mem_we;   obs_mem_adr = 32'(bus.mem_adr);
    obs_istall  = bus.i_stall;  obs_dstall = bus.d_stall;
    obs_ivalid  = bus.i_rvalid; obs_dvalid = bus.d_rvalid;
    obs_irdata  = bus.i_rdata;  obs_drdata = bus.d_rdata;

    e_force = rst_n && ir && (starve == STARVE_MAX);
    e_gd    = rst_n && dr && !e_force;
    e_gi    = rst_n && ir && !e_gd;

    check_eq("mem_en",   32'(obs_mem_en), 32'(e_gi || e_gd));
    check_eq("i_stall",  32'(obs_istall), 32'(rst_n && ir && !e_gi));
    check_eq("d_stall",  32'(obs_dstall), 32'(rst_n && dr && !e_gd));
    check_eq("i_rvalid", 32'(obs_ivalid), 32'(rst_n && m_pi));
    check_eq("d_rvalid", 32'(obs_dvalid), 32'(rst_n && (m_prd || m_pwr)));
    if (rst_n) begin
      check_eq("i_rdata", obs_irdata, m_pi  ? m_pdata : m_ihold);
      check_eq("d_rdata", obs_drdata, m_prd ? m_pdata : m_dhold);
    end
    if (e_gi || e_gd) begin
      check_eq("mem_adr", obs_mem_adr, (e_gd ? da : ia) >> 2);
      check_eq("mem_we",  32'(obs_mem_we), 32'(e_gd ? dw : 4'b0000));
    end
    if (e_gd) check_eq("mem_wdata", bus.mem_wdata, dd);

    @(posedge clk);
    if (!rst_n) begin
      starve = 0; m_pi = 0; m_prd = 0; m_pwr = 0; m_ihold = '0; m_dhold = '0;
    end else begin
      if (m_pi)  m_ihold = m_pdata;
      if (m_prd) m_dhold = m_pdata;
      m_pi = 0; m_prd = 0; m_pwr = 0;
      if (e_gd) begin
        if (dw != 4'b0000) begin
          ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dd, dw);
          m_pwr = 1;
        end else begin
          m_prd = 1;
          m_pdata = ref_mem[da[9:2]];
        end
      end else if (e_gi) begin
        m_pi = 1;
        m_pdata = ref_mem[ia[9:2]];
      end
      if (!ir || e_gi) starve = 0;
      else if (starve < STARVE_MAX) starve++;
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    starve = 0; m_pi = 0; m_prd = 0; m_pwr = 0;
    m_pdata = '0; m_ihold = '0; m_dhold = '0;
    bus.i_req = 0; bus.i_adr = '0; bus.d_req = 0; bus.d_we = '0;
    bus.d_adr = '0; bus.d_wdata = '0;

    // Reset with both sides requesting, then first fetch
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 32'h4000_0000, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check_eq("rst_mem_en", 32'(obs_mem_en), 32'd0);
      check_eq("rst_stalls", 32'({obs_istall, obs_dstall}), 32'd0);
    end
    cycle(1'b1, 1'b1, 32'h4000_0000, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("t1_mem_adr", obs_mem_adr, 32'h1000_0000);
    idle();
    check_eq("t1_ivalid", 32'(obs_ivalid), 32'd1);
    check_eq("t1_irdata", obs_irdata, seed_word(0));

    // Contention: D,D,D,I,D,D,D,I
    idle();
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, k <= 8, 32'h0000_0020, k <= 8, 4'h0, 32'h0000_0030, 32'h0);
      check_eq("ctn_istall", 32'(obs_istall), 32'((k <= 8) && (k != 4) && (k != 8)));
      check_eq("ctn_ivalid", 32'(obs_ivalid), 32'((k == 5) || (k == 9)));
    end

    // Partial store leaves held load data untouched
    idle();
    saved = obs_drdata;
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h0000_0104, 32'hAAAA_BEEF);
    check_eq("st_mem_we",  32'(obs_mem_we), 32'h3);
    check_eq("st_mem_adr", obs_mem_adr, 32'h41);
    idle();
    check_eq("st_dvalid", 32'(obs_dvalid), 32'd1);
    check_eq("st_drdata", obs_drdata, saved);

    // Load result held while the D-side idles
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0200, 32'h1234_5678);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
    idle();
    check_eq("ld_dvalid", 32'(obs_dvalid), 32'd1);
    check_eq("ld_drdata", obs_drdata, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      idle();
      check_eq("hold_drdata", obs_drdata, 32'h1234_5678);
      check_eq("hold_dvalid", 32'(obs_dvalid), 32'd0);
    end

    // Store then fetch of the same word
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b1, 32'h0000_0040, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();
    check_eq("raw_irdata", obs_irdata, 32'hDEAD_BEEF);

    // Reset while a fetch response is in flight
    cycle(1'b1, 1'b1, 32'h0000_0080, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("rmo_ivalid", 32'(obs_ivalid), 32'd0);
    idle();
    check_eq("rmo_ivalid2", 32'(obs_ivalid), 32'd0);
    check_eq("rmo_irdata",  obs_irdata, 32'h0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 39) != 0,
            $urandom_range(0, 3) != 0, 32'($urandom),
            $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
            32'($urandom), 32'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
